// File: rtl/ofmd_pkg.sv
// Shared sizes and FSM state encoding for the OFMD RAM sequencer.
package ofmd_pkg;

    localparam int unsigned OFMD_DEPTH  = 64;
    localparam int unsigned OFMD_ADDR_W = 6;
    localparam int unsigned OFMD_DATA_W = 8;
    localparam int unsigned OFMD_CNT_W  = OFMD_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } ofmd_state_t;

endpackage

// File: rtl/ofmd_addr_counter.sv
// Job word counter: clear / increment, exposes the RAM address bits and a
// terminal-count compare against a caller-supplied limit.
module ofmd_addr_counter #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_tc,
    output logic [CNT_W-2:0] o_addr,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One extra count bit lets a full-depth job end without wrapping.
    assign o_addr = r_cnt[CNT_W-2:0];
    assign o_tc   = (r_cnt == i_tc);

endmodule

// File: rtl/ofmd_seq_ctrl.sv
// OFMD RAM sequencer: fills the RAM from the conv-result stream, then drains it in order.
// Build option OFMD_RELU_EN: clamp negative (signed) results to zero on write.
module ofmd_seq_ctrl
    import ofmd_pkg::*;
#(
    parameter int unsigned DEPTH  = OFMD_DEPTH,
    parameter int unsigned ADDR_W = OFMD_ADDR_W,
    parameter int unsigned DATA_W = OFMD_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    ofmd_state_t      r_state;
    ofmd_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic [CNT_W-1:0] w_len_m1;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_len_ok;
    logic             w_cnt_clr;
    logic             w_wr_fire;
    logic             w_rd_issue;
    logic             w_wr_last;
    logic             w_rd_end;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_len_ok = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
    assign w_len_m1 = r_len - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_out_valid_nxt = r_out_valid;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_cnt_clr       = 1'b0;
        w_wr_fire       = 1'b0;
        w_rd_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nxt = FILL;
                        w_len_nxt   = num_words;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                w_wr_fire = in_valid;
                if (in_valid && w_wr_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // A new read may overlap the consumer taking the current word.
                w_rd_issue = !w_rd_end && (!r_out_valid || out_ready);
                if (w_rd_issue) begin
                    w_out_valid_nxt = 1'b1;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                end
                if (r_out_valid && out_ready && w_rd_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    ofmd_addr_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_wr_fire),
        .i_tc   (w_len_m1),
        .o_addr (w_wr_addr),
        .o_tc   (w_wr_last)
    );

    ofmd_addr_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_rd_issue),
        .i_tc   (r_len),
        .o_addr (w_rd_addr),
        .o_tc   (w_rd_end)
    );

    // RAM strobes are suppressed while reset is held.
    assign ram_write      = w_wr_fire & ~rst;
    assign ram_write_addr = w_wr_addr;
    assign ram_read       = w_rd_issue & ~rst;
    assign ram_read_addr  = w_rd_addr;

`ifdef OFMD_RELU_EN
    assign ram_wdata = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign ram_wdata = in_data;
`endif

    assign in_ready  = (r_state == FILL);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = ram_rdata;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_ofmd_seq_ctrl.sv
// Directed bench for ofmd_seq_ctrl with a behavioural 64x8 registered-read RAM.
module tb_ofmd_seq_ctrl;
    import ofmd_pkg::*;

    localparam int unsigned AW = OFMD_ADDR_W;
    localparam int unsigned DW = OFMD_DATA_W;
    localparam int unsigned CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_words;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          ram_write;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_read;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_rdata;
    logic          busy;
    logic          done;
    logic          err;

    ofmd_seq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_words      (num_words),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .ram_write      (ram_write),
        .ram_write_addr (ram_write_addr),
        .ram_wdata      (ram_wdata),
        .ram_read       (ram_read),
        .ram_read_addr  (ram_read_addr),
        .ram_rdata      (ram_rdata),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (ram_write) mem[ram_write_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_read_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wq[$];
    logic [AW-1:0] rq[$];
    logic [DW-1:0] oq[$];
    int            fq[$];
    int            done_cnt, done_cyc, err_cnt, stall_cnt, hold_err;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] feed [0:63];

    // Observe the values that the next rising edge will act on.
    always @(negedge clk) begin
        #2;
        if (ram_write) wq.push_back(ram_write_addr);
        if (ram_read)  rq.push_back(ram_read_addr);
        if (out_valid && out_ready && !rst) begin
            oq.push_back(out_data);
            fq.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (prev_stall) begin
            stall_cnt++;
            if (!out_valid || out_data !== prev_data) hold_err++;
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
    end

    task automatic clear_logs();
        wq.delete(); rq.delete(); oq.delete(); fq.delete();
        done_cnt = 0; done_cyc = 0; err_cnt = 0; stall_cnt = 0; hold_err = 0;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating
    task automatic do_job(input int n, input int mode);
        bit ok;
        clear_logs();
        @(negedge clk); start = 1'b1; num_words = CW'(n);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = feed[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 1; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (done_cnt > 0) ok = 1'b1;
            else out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
        end
        out_ready = 1'b0;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL job_timeout n=%0d got no done exp done", n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_done_err got %b%b exp 00", done, err); end
        n_vec++; if (ram_write !== 1'b0 || ram_read !== 1'b0) begin n_err++; $display("FAIL rst_ram got w%b r%b exp w0 r0", ram_write, ram_read); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (ram_write !== 1'b0 || ram_read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post_rst got w%b r%b b%b exp 000", ram_write, ram_read, busy); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic();
        feed[0] = 8'd5; feed[1] = 8'd6; feed[2] = 8'd7;
        do_job(3, 0);
        n_vec++; if (oq.size() != 3) begin n_err++; $display("FAIL t1_count got %0d exp 3", oq.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (oq[i] !== 8'(5 + i)) begin n_err++; $display("FAIL t1_out%0d got %h exp %h", i, oq[i], 8'(5 + i)); end
            n_vec++; if (mem[i] !== 8'(5 + i)) begin n_err++; $display("FAIL t1_mem%0d got %h exp %h", i, mem[i], 8'(5 + i)); end
        end
        n_vec++; if (fq[2] - fq[0] != 2) begin n_err++; $display("FAIL t1_consec got %0d exp 2", fq[2] - fq[0]); end
        n_vec++; if (done_cyc != fq[2] + 1) begin n_err++; $display("FAIL t1_done_lat got %0d exp %0d", done_cyc, fq[2] + 1); end
        n_vec++; if (done_cnt != 1 || busy !== 1'b0) begin n_err++; $display("FAIL t1_idle got done_cnt=%0d busy=%b exp 1 0", done_cnt, busy); end
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 64; i++) feed[i] = 8'(i);
        do_job(64, 0);
        n_vec++; if (oq.size() != 64) begin n_err++; $display("FAIL t2_count got %0d exp 64", oq.size()); end
        for (int i = 0; i < 64; i++) begin
            n_vec++; if (oq[i] !== 8'(i)) begin n_err++; $display("FAIL t2_out%0d got %h exp %h", i, oq[i], 8'(i)); end
        end
        n_vec++; if (wq.size() != 64 || wq[63] !== 6'd63) begin n_err++; $display("FAIL t2_writes got %0d last=%0d exp 64 63", wq.size(), wq[63]); end
        n_vec++; if (rq.size() != 64 || rq[63] !== 6'd63) begin n_err++; $display("FAIL t2_reads got %0d last=%0d exp 64 63", rq.size(), rq[63]); end
        n_vec++; if (fq[63] - fq[0] != 63) begin n_err++; $display("FAIL t2_throughput got %0d exp 63", fq[63] - fq[0]); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) feed[i] = 8'(8'hA1 + i);
        do_job(4, 1);
        n_vec++; if (oq.size() != 4) begin n_err++; $display("FAIL t3_count got %0d exp 4", oq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (oq[i] !== 8'(8'hA1 + i)) begin n_err++; $display("FAIL t3_out%0d got %h exp %h", i, oq[i], 8'(8'hA1 + i)); end
        end
        n_vec++; if (stall_cnt == 0) begin n_err++; $display("FAIL t3_stalls got %0d exp >0", stall_cnt); end
        n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL t3_hold got %0d exp 0", hold_err); end
        n_vec++; if (rq.size() != 4) begin n_err++; $display("FAIL t3_reads got %0d exp 4", rq.size()); end
    endtask

    task automatic test_illegal_len();
        int bad [2];
        bad[0] = 0; bad[1] = 65;
        foreach (bad[k]) begin
            clear_logs();
            @(negedge clk); start = 1'b1; num_words = CW'(bad[k]); in_valid = 1'b1; in_data = 8'h55;
            @(negedge clk); start = 1'b0; #1;
            n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL t4_err%0d got err=%b busy=%b exp 1 0", bad[k], err, busy); end
            @(negedge clk); #1;
            n_vec++; if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL t4_after%0d got err=%b busy=%b rdy=%b exp 0 0 0", bad[k], err, busy, in_ready); end
            in_valid = 1'b0;
            @(negedge clk);
            n_vec++; if (wq.size() != 0 || rq.size() != 0 || err_cnt != 1) begin n_err++; $display("FAIL t4_ram%0d got w=%0d r=%0d errs=%0d exp 0 0 1", bad[k], wq.size(), rq.size(), err_cnt); end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit hit;
        clear_logs();
        @(negedge clk); start = 1'b1; num_words = CW'(8);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (oq.size() >= 3) hit = 1'b1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL t5_wait got %0d outputs exp 3", oq.size()); end
        rst = 1'b1; #1;
        n_vec++; if (ram_read !== 1'b0 || ram_write !== 1'b0) begin n_err++; $display("FAIL t5_ram_in_rst got r%b w%b exp 0 0", ram_read, ram_write); end
        @(negedge clk); rst = 1'b0; #1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL t5_idle got busy=%b ov=%b exp 0 0", busy, out_valid); end
        n_vec++; if (ram_read !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL t5_quiet got rd=%b done=%b exp 0 0", ram_read, done); end
        n_vec++; if (oq.size() != 3 || oq[2] !== 8'h12) begin n_err++; $display("FAIL t5_partial got %0d last=%h exp 3 12", oq.size(), oq[2]); end
        out_ready = 1'b0;
        feed[0] = 8'h33; feed[1] = 8'h44;
        do_job(2, 0);
        n_vec++; if (oq.size() != 2 || oq[0] !== 8'h33 || oq[1] !== 8'h44) begin n_err++; $display("FAIL t5_rerun got n=%0d %h %h exp 2 33 44", oq.size(), oq[0], oq[1]); end
    endtask

    task automatic test_relu();
        logic [DW-1:0] exp0;
`ifdef OFMD_RELU_EN
        exp0 = 8'h00;
`else
        exp0 = 8'h85;
`endif
        feed[0] = 8'h85; feed[1] = 8'h12;
        do_job(2, 0);
        n_vec++; if (oq[0] !== exp0) begin n_err++; $display("FAIL t6_neg got %h exp %h", oq[0], exp0); end
        n_vec++; if (oq[1] !== 8'h12) begin n_err++; $display("FAIL t6_pos got %h exp 12", oq[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_depth();
        test_backpressure();
        test_illegal_len();
        test_reset_mid_drain();
        test_relu();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
